// File: rtl/simple_mem_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and MEM-stage data access.
// Define ARB_STATS_EN to add the stat_stall / stat_conflict saturating counters.
module simple_mem_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    output logic          if_stall,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_q
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]   stat_stall,
    output logic [15:0]   stat_conflict
`endif
);

    localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

    logic [3:0]        r_wait_cnt;
    logic [3:0]        w_wait_next;
    logic              w_if_win;
    logic              w_dm_win;
    logic              w_rd_gnt;
    logic [AW-1:0]     r_last_addr;
    logic [RD_LAT-1:0] r_tag_vld;
    logic [RD_LAT-1:0] r_tag_own;
    logic [RD_LAT-1:0] w_tag_vld_in;
    logic [RD_LAT-1:0] w_tag_own_in;
    logic              w_ret_vld;
    logic              w_ret_own;
    logic [DW-1:0]     r_if_rdata;
    logic [DW-1:0]     r_dm_rdata;

    // Data access has priority; a fetch denied MAX_WAIT cycles in a row takes the port.
    always_comb begin
        w_if_win = 1'b0;
        w_dm_win = 1'b0;
        if (if_req && dm_req) begin
            if (r_wait_cnt == LP_MAX_WAIT) begin
                w_if_win = 1'b1;
            end else begin
                w_dm_win = 1'b1;
            end
        end else begin
            w_if_win = if_req;
            w_dm_win = dm_req;
        end
    end

    always_comb begin
        w_wait_next = r_wait_cnt;
        if (!if_req || w_if_win) begin
            w_wait_next = 4'd0;
        end else if (r_wait_cnt < LP_MAX_WAIT) begin
            w_wait_next = r_wait_cnt + 4'd1;
        end
    end

    assign w_rd_gnt = w_if_win | (w_dm_win & ~dm_we);

    assign if_gnt    = w_if_win;
    assign dm_gnt    = w_dm_win;
    assign if_stall  = if_req & ~w_if_win;
    assign ram_we    = w_dm_win & dm_we;
    assign ram_wdata = dm_wdata;
    assign ram_addr  = w_if_win ? if_addr : (w_dm_win ? dm_addr : r_last_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt  <= 4'd0;
            r_last_addr <= '0;
        end else begin
            r_wait_cnt <= w_wait_next;
            if (w_if_win || w_dm_win) begin
                r_last_addr <= ram_addr;
            end
        end
    end

    // One tag stage per cycle of RAM latency; owner 1 means the data port.
    assign w_tag_vld_in[0] = w_rd_gnt;
    assign w_tag_own_in[0] = w_dm_win;

    genvar gi;
    generate
        for (gi = 1; gi < RD_LAT; gi++) begin : g_tag
            assign w_tag_vld_in[gi] = r_tag_vld[gi-1];
            assign w_tag_own_in[gi] = r_tag_own[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_vld <= '0;
            r_tag_own <= '0;
        end else begin
            r_tag_vld <= w_tag_vld_in;
            r_tag_own <= w_tag_own_in;
        end
    end

    assign w_ret_vld = r_tag_vld[RD_LAT-1];
    assign w_ret_own = r_tag_own[RD_LAT-1];

    assign if_rvalid = w_ret_vld & ~w_ret_own;
    assign dm_rvalid = w_ret_vld & w_ret_own;
    assign if_rdata  = if_rvalid ? ram_q : r_if_rdata;
    assign dm_rdata  = dm_rvalid ? ram_q : r_dm_rdata;

    // Each requester keeps its last returned word until its next read completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            if (if_rvalid) begin
                r_if_rdata <= ram_q;
            end
            if (dm_rvalid) begin
                r_dm_rdata <= ram_q;
            end
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] r_stat_stall;
    logic [15:0] r_stat_conflict;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_stall    <= 16'd0;
            r_stat_conflict <= 16'd0;
        end else begin
            if (if_stall && (r_stat_stall != 16'hFFFF)) begin
                r_stat_stall <= r_stat_stall + 16'd1;
            end
            if (if_req && dm_req && (r_stat_conflict != 16'hFFFF)) begin
                r_stat_conflict <= r_stat_conflict + 16'd1;
            end
        end
    end

    assign stat_stall    = r_stat_stall;
    assign stat_conflict = r_stat_conflict;
`endif

endmodule

// File: tb/tb_simple_mem_arbiter.sv
// Bench: two arbiters (read latency 1 and 3) on shared random stimulus, checked against a
// queue-based model of grants, read returns and held data, plus literal directed checks.
module tb_simple_mem_arbiter;

    localparam int MAX_WAIT = 3;
    localparam int LAT_A    = 1;
    localparam int LAT_B    = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, tb_init;
    logic        if_req, dm_req, dm_we;
    logic [15:0] if_addr, dm_addr, dm_wdata;

    logic        a_if_gnt, a_if_rvalid, a_if_stall, a_dm_gnt, a_dm_rvalid, a_ram_we;
    logic [15:0] a_if_rdata, a_dm_rdata, a_ram_addr, a_ram_wdata, a_ram_q;
    logic        b_if_gnt, b_if_rvalid, b_if_stall, b_dm_gnt, b_dm_rvalid, b_ram_we;
    logic [15:0] b_if_rdata, b_dm_rdata, b_ram_addr, b_ram_wdata, b_ram_q;
`ifdef ARB_STATS_EN
    logic [15:0] a_stat_stall, a_stat_conflict, b_stat_stall, b_stat_conflict;
`endif

    int checks   = 0;
    int failures = 0;

    simple_mem_arbiter #(.AW(16), .DW(16), .RD_LAT(LAT_A), .MAX_WAIT(MAX_WAIT)) u_a (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(a_if_gnt), .if_rvalid(a_if_rvalid),
        .if_rdata(a_if_rdata), .if_stall(a_if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(a_dm_gnt), .dm_rvalid(a_dm_rvalid), .dm_rdata(a_dm_rdata),
        .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata), .ram_we(a_ram_we), .ram_q(a_ram_q)
`ifdef ARB_STATS_EN
        , .stat_stall(a_stat_stall), .stat_conflict(a_stat_conflict)
`endif
    );

    simple_mem_arbiter #(.AW(16), .DW(16), .RD_LAT(LAT_B), .MAX_WAIT(MAX_WAIT)) u_b (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid),
        .if_rdata(b_if_rdata), .if_stall(b_if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(b_dm_gnt), .dm_rvalid(b_dm_rvalid), .dm_rdata(b_dm_rdata),
        .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_we(b_ram_we), .ram_q(b_ram_q)
`ifdef ARB_STATS_EN
        , .stat_stall(b_stat_stall), .stat_conflict(b_stat_conflict)
`endif
    );

    function automatic logic [15:0] init_word(input int i);
        if (i == 4) return 16'h8A05;
        return 16'hC000 + 16'(i);
    endfunction

    // Environment RAMs: 256 words, write-first, q delayed by the instance's latency.
    logic [15:0] mem_a [0:255];
    logic [15:0] mem_b [0:255];
    logic [15:0] qa;
    logic [15:0] qb [0:2];

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= init_word(i);
        end else if (a_ram_we) begin
            mem_a[a_ram_addr[7:0]] <= a_ram_wdata;
        end
        qa <= a_ram_we ? a_ram_wdata : mem_a[a_ram_addr[7:0]];
    end
    assign a_ram_q = qa;

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 256; i++) mem_b[i] <= init_word(i);
        end else if (b_ram_we) begin
            mem_b[b_ram_addr[7:0]] <= b_ram_wdata;
        end
        qb[0] <= b_ram_we ? b_ram_wdata : mem_b[b_ram_addr[7:0]];
        qb[1] <= qb[0];
        qb[2] <= qb[1];
    end
    assign b_ram_q = qb[2];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic cmp_inst(input string n,
                            input logic ig, dg, st, we, irv, drv,
                            input logic [15:0] ra, ird, drd, wd,
                            input logic eig, edg, est, ewe, eirv, edrv,
                            input logic [15:0] era, eird, edrd, ewd);
        chk({n, ".if_gnt"}, 16'(ig), 16'(eig));
        chk({n, ".dm_gnt"}, 16'(dg), 16'(edg));
        chk({n, ".if_stall"}, 16'(st), 16'(est));
        chk({n, ".ram_we"}, 16'(we), 16'(ewe));
        chk({n, ".ram_addr"}, ra, era);
        chk({n, ".if_rvalid"}, 16'(irv), 16'(eirv));
        chk({n, ".dm_rvalid"}, 16'(drv), 16'(edrv));
        chk({n, ".if_rdata"}, ird, eird);
        chk({n, ".dm_rdata"}, drd, edrd);
        if (ewe) chk({n, ".ram_wdata"}, wd, ewd);
    endtask

    // Reference model, evaluated once per cycle on the falling edge.
    typedef struct packed {
        int          due;
        logic        own;
        logic [15:0] data;
    } ret_t;

    initial begin : model
        ret_t        qa_m[$];
        ret_t        qb_m[$];
        ret_t        r;
        logic [15:0] shadow [0:255];
        int          cyc;
        int          m_wait;
        logic [15:0] m_last, ha_if, ha_dm, hb_if, hb_dm, m_stall, m_conf;
        logic        e_ig, e_dg, e_we, ra_v, ra_o, rb_v, rb_o;
        logic [15:0] e_addr, ra_d, rb_d, ea_ird, ea_drd, eb_ird, eb_drd;
        cyc = 0;
        m_wait = 0; m_last = 0; ha_if = 0; ha_dm = 0; hb_if = 0; hb_dm = 0;
        m_stall = 0; m_conf = 0;
        for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                m_wait = 0; m_last = 0; ha_if = 0; ha_dm = 0; hb_if = 0; hb_dm = 0;
                m_stall = 0; m_conf = 0;
                qa_m.delete();
                qb_m.delete();
            end
            e_ig = 1'b0;
            e_dg = 1'b0;
            if (if_req && dm_req) begin
                if (m_wait == MAX_WAIT) e_ig = 1'b1;
                else e_dg = 1'b1;
            end else begin
                e_ig = if_req;
                e_dg = dm_req;
            end
            e_addr = e_ig ? if_addr : (e_dg ? dm_addr : m_last);
            e_we   = e_dg & dm_we;

            ra_v = 1'b0; ra_o = 1'b0; ra_d = 16'h0;
            if (qa_m.size() > 0 && qa_m[0].due == cyc) begin
                r = qa_m.pop_front();
                ra_v = 1'b1; ra_o = r.own; ra_d = r.data;
            end
            rb_v = 1'b0; rb_o = 1'b0; rb_d = 16'h0;
            if (qb_m.size() > 0 && qb_m[0].due == cyc) begin
                r = qb_m.pop_front();
                rb_v = 1'b1; rb_o = r.own; rb_d = r.data;
            end
            ea_ird = (ra_v && !ra_o) ? ra_d : ha_if;
            ea_drd = (ra_v && ra_o) ? ra_d : ha_dm;
            eb_ird = (rb_v && !rb_o) ? rb_d : hb_if;
            eb_drd = (rb_v && rb_o) ? rb_d : hb_dm;

            cmp_inst("A", a_if_gnt, a_dm_gnt, a_if_stall, a_ram_we, a_if_rvalid, a_dm_rvalid,
                     a_ram_addr, a_if_rdata, a_dm_rdata, a_ram_wdata,
                     e_ig, e_dg, if_req & ~e_ig, e_we, ra_v & ~ra_o, ra_v & ra_o,
                     e_addr, ea_ird, ea_drd, dm_wdata);
            cmp_inst("B", b_if_gnt, b_dm_gnt, b_if_stall, b_ram_we, b_if_rvalid, b_dm_rvalid,
                     b_ram_addr, b_if_rdata, b_dm_rdata, b_ram_wdata,
                     e_ig, e_dg, if_req & ~e_ig, e_we, rb_v & ~rb_o, rb_v & rb_o,
                     e_addr, eb_ird, eb_drd, dm_wdata);
`ifdef ARB_STATS_EN
            chk("A.stat_stall", a_stat_stall, m_stall);
            chk("A.stat_conflict", a_stat_conflict, m_conf);
            chk("B.stat_stall", b_stat_stall, m_stall);
            chk("B.stat_conflict", b_stat_conflict, m_conf);
`endif
            if (rst_n) begin
                ha_if = ea_ird; ha_dm = ea_drd; hb_if = eb_ird; hb_dm = eb_drd;
                if (if_req && !e_ig) begin
                    if (m_wait < MAX_WAIT) m_wait++;
                end else begin
                    m_wait = 0;
                end
                if (e_ig || e_dg) m_last = e_addr;
                if (e_we) begin
                    shadow[e_addr[7:0]] = dm_wdata;
                end else if (e_ig || e_dg) begin
                    qa_m.push_back('{due: cyc + LAT_A, own: e_dg, data: shadow[e_addr[7:0]]});
                    qb_m.push_back('{due: cyc + LAT_B, own: e_dg, data: shadow[e_addr[7:0]]});
                end
                if (if_req && !e_ig && m_stall != 16'hFFFF) m_stall++;
                if (if_req && dm_req && m_conf != 16'hFFFF) m_conf++;
            end
        end
    end

    task automatic drv(input logic ir, input logic [15:0] ia, input logic dr, input logic dw,
                       input logic [15:0] da, input logic [15:0] dd);
        if_req = ir; if_addr = ia; dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dd;
    endtask
    task automatic idle();
        drv(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask
    task automatic next();
        @(posedge clk);
        #1;
    endtask
    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation time limit");
    end

    initial begin : stim
        logic [7:0] pat;
        rst_n = 1'b0;
        tb_init = 1'b1;
        idle();
        mid();
        chk("rst_if_rvalid", 16'(a_if_rvalid), 16'h0);
        chk("rst_if_rdata", a_if_rdata, 16'h0);
        chk("rst_ram_addr", a_ram_addr, 16'h0);
        chk("rst_b_dm_rdata", b_dm_rdata, 16'h0);
        next();
        tb_init = 1'b0;
        next();
        rst_n = 1'b1;

        // Isolated fetch.
        drv(1'b1, 16'h0004, 1'b0, 1'b0, 16'h0, 16'h0);
        mid();
        chk("iso_if_gnt", 16'(a_if_gnt), 16'h1);
        next();
        idle();
        mid();
        chk("iso_if_rvalid", 16'(a_if_rvalid), 16'h1);
        chk("iso_if_rdata", a_if_rdata, 16'h8A05);
        chk("iso_dm_rvalid", 16'(a_dm_rvalid), 16'h0);
        repeat (4) next();

        // Conflict for one cycle, then fetch alone.
        drv(1'b1, 16'h0004, 1'b1, 1'b0, 16'h0010, 16'h0);
        mid();
        chk("conf_dm_gnt", 16'(a_dm_gnt), 16'h1);
        chk("conf_if_stall", 16'(a_if_stall), 16'h1);
        next();
        drv(1'b1, 16'h0004, 1'b0, 1'b0, 16'h0, 16'h0);
        mid();
        chk("conf_if_gnt", 16'(a_if_gnt), 16'h1);
        chk("conf_dm_rvalid", 16'(a_dm_rvalid), 16'h1);
        chk("conf_dm_rdata", a_dm_rdata, 16'hC010);
        next();
        idle();
        mid();
        chk("conf_if_rvalid", 16'(a_if_rvalid), 16'h1);
        chk("conf_if_rdata", a_if_rdata, 16'h8A05);
        repeat (4) next();

        // Starvation: dm,dm,dm,if repeating while both hold requests.
        pat = 8'b1000_1000;
        drv(1'b1, 16'h0008, 1'b1, 1'b0, 16'h0011, 16'h0);
        for (int k = 0; k < 8; k++) begin
            mid();
            chk("starve_if_gnt", 16'(a_if_gnt), 16'(pat[k]));
            chk("starve_dm_gnt", 16'(a_dm_gnt), 16'(!pat[k]));
            next();
        end
        idle();
        repeat (4) next();

        // Write then read of the same address.
        drv(1'b0, 16'h0, 1'b1, 1'b1, 16'h0020, 16'h1234);
        mid();
        chk("wr_ram_we", 16'(a_ram_we), 16'h1);
        chk("wr_ram_addr", a_ram_addr, 16'h0020);
        next();
        drv(1'b0, 16'h0, 1'b1, 1'b0, 16'h0020, 16'h0);
        mid();
        chk("rd_ram_we", 16'(a_ram_we), 16'h0);
        chk("wr_no_rvalid", 16'(a_dm_rvalid), 16'h0);
        next();
        idle();
        mid();
        chk("wrrd_dm_rvalid", 16'(a_dm_rvalid), 16'h1);
        chk("wrrd_dm_rdata", a_dm_rdata, 16'h1234);
        next();
        next();
        mid();
        chk("wrrd_b_dm_rvalid", 16'(b_dm_rvalid), 16'h1);
        chk("wrrd_b_dm_rdata", b_dm_rdata, 16'h1234);
        repeat (3) next();

        // Latency-3 back-to-back fetches of 0,1,2.
        for (int k = 0; k < 6; k++) begin
            if (k < 3) drv(1'b1, 16'(k), 1'b0, 1'b0, 16'h0, 16'h0);
            else idle();
            mid();
            chk("b2b_if_rvalid", 16'(b_if_rvalid), 16'(k >= 3));
            if (k >= 3) chk("b2b_if_rdata", b_if_rdata, 16'hC000 + 16'(k - 3));
            next();
        end
        repeat (2) next();

        // Reset while reads are in flight.
        drv(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0);
        next();
        drv(1'b1, 16'h0001, 1'b0, 1'b0, 16'h0, 16'h0);
        next();
        idle();
        rst_n = 1'b0;
        mid();
        chk("mrst_b_if_rvalid", 16'(b_if_rvalid), 16'h0);
        chk("mrst_b_if_rdata", b_if_rdata, 16'h0);
        chk("mrst_a_if_rvalid", 16'(a_if_rvalid), 16'h0);
        chk("mrst_a_if_rdata", a_if_rdata, 16'h0);
        chk("mrst_ram_addr", b_ram_addr, 16'h0);
        next();
        next();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            mid();
            chk("post_rst_b_rvalid", 16'(b_if_rvalid | b_dm_rvalid), 16'h0);
            chk("post_rst_a_rvalid", 16'(a_if_rvalid | a_dm_rvalid), 16'h0);
            next();
        end

`ifdef ARB_STATS_EN
        // Five isolated conflict cycles, each followed by an idle cycle.
        for (int k = 0; k < 5; k++) begin
            drv(1'b1, 16'h0030, 1'b1, 1'b0, 16'h0031, 16'h0);
            next();
            idle();
            next();
        end
        mid();
        chk("stat_conflict_5", a_stat_conflict, 16'd5);
        chk("stat_stall_5", a_stat_stall, 16'd5);
        next();
`endif

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                idle();
                rst_n = 1'b0;
                next();
                next();
                rst_n = 1'b1;
            end
            drv($urandom_range(0, 99) < 60, 16'($urandom_range(0, 63)),
                $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 40,
                16'($urandom_range(0, 63)), 16'($urandom));
            next();
        end
        idle();
        repeat (5) next();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
